etc_block_collector: RTL and testbench

ETC_BLOCK_COLLECTOR -- requirements
Module: etc_block_collector

---
 rtl/etc_pkg.sv | 19 +
 rtl/etc_block_buf.sv | 30 +++
 rtl/etc_block_collector.sv | 138 +++++++++++++
 tb/tb_etc_block_collector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared types and sizes for the ETC block collector: FSM encoding, pixel/row
// widths, pixel count and watchdog limit.
`timescale 1ns/1ps
package etc_pkg;
  localparam int PIX_W     = 32;
  localparam int ROW_W     = 128;
  localparam int NPIX      = 16;
  localparam int NLANE     = 4;
  localparam int IDX_W     = 4;
  localparam int ROW_IDX_W = 2;
  localparam int WDOG_MAX  = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } etc_state_e;
endpackage

// File: rtl/etc_block_buf.sv
// 16 x 32-bit pixel register file: indexed write, row-select read of four lanes
// where lane x of row y holds pixel p = 4x + y.
`timescale 1ns/1ps
module etc_block_buf
  import etc_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [IDX_W-1:0]     i_wr_addr,
  input  logic [PIX_W-1:0]     i_wr_data,
  input  logic [ROW_IDX_W-1:0] i_rd_row,
  output logic [ROW_W-1:0]     o_rd_data
);
  logic [PIX_W-1:0] r_mem [NPIX];

  // Contents are only read after a full block has been written, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      logic [IDX_W-1:0] w_addr;
      assign w_addr = {2'(gi), i_rd_row};
      assign o_rd_data[PIX_W*gi +: PIX_W] = r_mem[w_addr];
    end
  endgenerate
endmodule

// File: rtl/etc_block_collector.sv
// Collects 16 ETC pixels from a generator into a 4x4 block and emits it row by
// row. Optional WAIT-state watchdog selected by `define ETC_COLLECT_WDOG_EN.
`timescale 1ns/1ps
module etc_block_collector
  import etc_pkg::*;
(
  input  logic                 sclk,
  input  logic                 rsrt,
  input  logic                 blk_rts,
  output logic                 blk_rtr,
  output logic                 pix_req,
  output logic [IDX_W-1:0]     pix_idx,
  input  logic                 pix_rts,
  input  logic [7:0]           pix_r,
  input  logic [7:0]           pix_g,
  input  logic [7:0]           pix_b,
  input  logic [7:0]           pix_a,
  output logic                 row_rts,
  input  logic                 row_rtr,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic [ROW_W-1:0]     row_data,
  output logic                 blk_done,
  output logic                 err
);
  etc_state_e             r_state;
  logic                   r_pix_req;
  logic [IDX_W-1:0]       r_pix_idx;
  logic                   r_row_rts;
  logic [ROW_IDX_W-1:0]   r_row_idx;

  logic                   w_wr_en;
  logic [PIX_W-1:0]       w_wr_data;
  logic [ROW_W-1:0]       w_rd_data;
  logic                   w_row_acc;

`ifdef ETC_COLLECT_WDOG_EN
  logic [7:0]             r_wdog;
  logic                   r_err;
`endif

  assign w_wr_en   = (r_state == ST_WAIT) && pix_rts;
  assign w_wr_data = {pix_a, pix_b, pix_g, pix_r};
  assign w_row_acc = r_row_rts && row_rtr;

  etc_block_buf u_buf (
    .i_clk     (sclk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_pix_idx),
    .i_wr_data (w_wr_data),
    .i_rd_row  (r_row_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge sclk) begin
    if (rsrt) begin
      r_state   <= ST_IDLE;
      r_pix_req <= 1'b0;
      r_pix_idx <= '0;
      r_row_rts <= 1'b0;
      r_row_idx <= '0;
`ifdef ETC_COLLECT_WDOG_EN
      r_wdog    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (blk_rts) begin
            r_state   <= ST_REQ;
            r_pix_req <= 1'b1;
            r_pix_idx <= '0;
`ifdef ETC_COLLECT_WDOG_EN
            r_err     <= 1'b0;
`endif
          end
        end
        ST_REQ: begin
          r_pix_req <= 1'b0;
          r_state   <= ST_WAIT;
`ifdef ETC_COLLECT_WDOG_EN
          r_wdog    <= '0;
`endif
        end
        ST_WAIT: begin
          if (pix_rts) begin
            if (r_pix_idx == 4'(NPIX - 1)) begin
              r_state   <= ST_EMIT;
              r_row_rts <= 1'b1;
              r_row_idx <= '0;
            end else begin
              r_pix_idx <= r_pix_idx + 1'b1;
              r_pix_req <= 1'b1;
              r_state   <= ST_REQ;
            end
          end
`ifdef ETC_COLLECT_WDOG_EN
          // A lost pixel is re-requested at the same index; err stays set
          // until the next block is accepted.
          else if (r_wdog == 8'(WDOG_MAX - 1)) begin
            r_pix_req <= 1'b1;
            r_state   <= ST_REQ;
            r_err     <= 1'b1;
          end else begin
            r_wdog    <= r_wdog + 1'b1;
          end
`endif
        end
        ST_EMIT: begin
          if (w_row_acc) begin
            if (r_row_idx == 2'd3) begin
              r_row_rts <= 1'b0;
              r_row_idx <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign blk_rtr  = (r_state == ST_IDLE) && !rsrt;
  assign pix_req  = r_pix_req;
  assign pix_idx  = r_pix_idx;
  assign row_rts  = r_row_rts;
  assign row_idx  = r_row_idx;
  assign row_data = r_row_rts ? w_rd_data : '0;
  // Pulse coincides with the handshake of row 3 so a new block can follow at once.
  assign blk_done = w_row_acc && (r_row_idx == 2'd3) && !rsrt;

`ifdef ETC_COLLECT_WDOG_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_etc_block_collector.sv
// Directed bench for etc_block_collector; watchdog scenario only when
// ETC_COLLECT_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_etc_block_collector;
  logic         sclk = 1'b0;
  logic         rsrt = 1'b1;
  logic         blk_rts = 1'b0;
  logic         blk_rtr;
  logic         pix_req;
  logic [3:0]   pix_idx;
  logic         pix_rts = 1'b0;
  logic [7:0]   pix_r = '0, pix_g = '0, pix_b = '0, pix_a = '0;
  logic         row_rts;
  logic         row_rtr = 1'b1;
  logic [1:0]   row_idx;
  logic [127:0] row_data;
  logic         blk_done;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  etc_block_collector dut (
    .sclk(sclk), .rsrt(rsrt), .blk_rts(blk_rts), .blk_rtr(blk_rtr),
    .pix_req(pix_req), .pix_idx(pix_idx), .pix_rts(pix_rts),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_a(pix_a),
    .row_rts(row_rts), .row_rtr(row_rtr), .row_idx(row_idx),
    .row_data(row_data), .blk_done(blk_done), .err(err)
  );

  always #5 sclk = ~sclk;

  // Pixel generator: answers each request one cycle later, optionally
  // ignoring the first hold_left requests for pixel hold_idx.
  logic       req_q = 1'b0;
  logic [3:0] idx_q = '0;
  int         hold_idx = -1;
  int         hold_left = 0;

  always @(negedge sclk) begin
    req_q = pix_req;
    idx_q = pix_idx;
  end

  always @(posedge sclk) begin
    #1;
    if (req_q && !(int'(idx_q) == hold_idx && hold_left > 0)) begin
      pix_rts = 1'b1;
      pix_r   = {4'h0, idx_q};
      pix_g   = 8'h10 + {4'h0, idx_q};
      pix_b   = 8'h20 + {4'h0, idx_q};
      pix_a   = 8'hFF;
    end else begin
      if (req_q) hold_left = hold_left - 1;
      pix_rts = 1'b0;
      {pix_a, pix_b, pix_g, pix_r} = '0;
    end
  end

  function automatic logic [127:0] exp_row(input int y);
    logic [127:0] v;
    int p;
    v = '0;
    for (int x = 0; x < 4; x++) begin
      p = 4 * x + y;
      v[32*x +: 32] = {8'hFF, 8'(32 + p), 8'(16 + p), 8'(p)};
    end
    return v;
  endfunction

  typedef struct {
    int first_req, last_req, nreq, idx_bad;
    int first_row, rows_ok, nrows, stall, stall_bad, zero_bad;
    int done_cyc, ndone, rtr_busy, rtr0, rtr_after;
    int retry_gap, retry_idx, retry_err, err_c1, err_end;
    logic [31:0] lane12;
  } obs_t;

  // Runs one block; cycle 0 is the cycle blk_rts is high. Records observations.
  task automatic run_block(input int stall_len, input bit pulse7, input bit chain_out,
                           input bit chain_in, output obs_t o);
    int pend;
    logic [3:0] last_idx;
    o = '{default: 0};
    o.first_req = -1; o.first_row = -1; o.done_cyc = -1; o.retry_gap = -1;
    o.retry_idx = -1; o.retry_err = -1; o.err_c1 = -1; o.err_end = -1;
    last_idx = '0;
    pend = 0;
    if (!chain_in) begin
      @(posedge sclk); #1 blk_rts = 1'b1; row_rtr = 1'b1;
    end
    #1 o.rtr0 = int'(blk_rtr);
    for (int t = 1; t < 1000; t++) begin
      @(posedge sclk); #1;
      blk_rts = (pend != 0) || (chain_out && o.done_cyc >= 0 && t == o.done_cyc + 1);
      pend = 0;
      row_rtr = !(row_rts && row_idx == 2'd2 && o.stall < stall_len);
      #1;
      if (t == 1) o.err_c1 = int'(err);
      if (pix_req) begin
        if (o.nreq > 0 && pix_idx == last_idx) begin
          o.retry_gap = t - o.last_req;
          o.retry_idx = int'(pix_idx);
          o.retry_err = int'(err);
        end else begin
          if (pix_idx != 4'(o.nreq)) o.idx_bad++;
          o.nreq++;
        end
        if (o.first_req < 0) o.first_req = t;
        o.last_req = t;
        last_idx = pix_idx;
        if (pulse7 && pix_idx == 4'd7) pend = 1;
      end
      if (row_rts) begin
        if (o.first_row < 0) o.first_row = t;
        if (!row_rtr) begin
          o.stall++;
          if (row_idx !== 2'd2 || row_data !== exp_row(2)) o.stall_bad++;
        end else begin
          if (int'(row_idx) == o.nrows && row_data === exp_row(o.nrows)) o.rows_ok++;
          if (o.nrows == 1) o.lane12 = row_data[95:64];
          o.nrows++;
        end
      end else if (row_data !== '0) begin
        o.zero_bad++;
      end
      if (o.done_cyc < 0 && blk_rtr) o.rtr_busy++;
      if (blk_done) begin
        o.ndone++;
        o.done_cyc = t;
        o.err_end = int'(err);
      end
      if (o.done_cyc >= 0 && t > o.done_cyc) begin
        o.rtr_after = int'(blk_rtr);
        break;
      end
    end
    $display("block: reqs=%0d first_req=%0d first_row=%0d rows=%0d done=%0d stall=%0d",
             o.nreq, o.first_req, o.first_row, o.nrows, o.done_cyc, o.stall);
  endtask

  task automatic test_reset();
    rsrt = 1'b1;
    repeat (3) @(posedge sclk);
    #2;
    n_cmp++; if (blk_rtr !== 1'b0) begin $display("FAIL reset_blk_rtr got %b want 0", blk_rtr); n_bad++; end
    n_cmp++; if (pix_req !== 1'b0) begin $display("FAIL reset_pix_req got %b want 0", pix_req); n_bad++; end
    n_cmp++; if (pix_idx !== 4'd0) begin $display("FAIL reset_pix_idx got %0d want 0", pix_idx); n_bad++; end
    n_cmp++; if (row_rts !== 1'b0) begin $display("FAIL reset_row_rts got %b want 0", row_rts); n_bad++; end
    n_cmp++; if (row_idx !== 2'd0) begin $display("FAIL reset_row_idx got %0d want 0", row_idx); n_bad++; end
    n_cmp++; if (row_data !== 128'd0) begin $display("FAIL reset_row_data got %h want 0", row_data); n_bad++; end
    n_cmp++; if (blk_done !== 1'b0) begin $display("FAIL reset_blk_done got %b want 0", blk_done); n_bad++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); n_bad++; end
    @(posedge sclk); #1 rsrt = 1'b0; #1;
    n_cmp++; if (blk_rtr !== 1'b1) begin $display("FAIL idle_blk_rtr got %b want 1", blk_rtr); n_bad++; end
  endtask

  task automatic test_basic();
    obs_t o;
    run_block(0, 1'b0, 1'b0, 1'b0, o);
    n_cmp++; if (o.rtr0 !== 1) begin $display("FAIL basic_rtr0 got %0d want 1", o.rtr0); n_bad++; end
    n_cmp++; if (o.first_req !== 1) begin $display("FAIL basic_first_req got %0d want 1", o.first_req); n_bad++; end
    n_cmp++; if (o.last_req !== 31) begin $display("FAIL basic_last_req got %0d want 31", o.last_req); n_bad++; end
    n_cmp++; if (o.nreq !== 16 || o.idx_bad !== 0) begin $display("FAIL basic_reqs got %0d/%0d want 16/0", o.nreq, o.idx_bad); n_bad++; end
    n_cmp++; if (o.first_row !== 33) begin $display("FAIL basic_first_row got %0d want 33", o.first_row); n_bad++; end
    n_cmp++; if (o.rows_ok !== 4) begin $display("FAIL basic_rows got %0d want 4", o.rows_ok); n_bad++; end
    n_cmp++; if (o.lane12 !== 32'hFF291909) begin $display("FAIL basic_lane12 got %h want ff291909", o.lane12); n_bad++; end
    n_cmp++; if (o.done_cyc !== 36 || o.ndone !== 1) begin $display("FAIL basic_done got %0d x%0d want 36 x1", o.done_cyc, o.ndone); n_bad++; end
    n_cmp++; if (o.zero_bad !== 0) begin $display("FAIL basic_zero_data got %0d want 0", o.zero_bad); n_bad++; end
    n_cmp++; if (o.rtr_busy !== 0 || o.rtr_after !== 1) begin $display("FAIL basic_blk_rtr got %0d/%0d want 0/1", o.rtr_busy, o.rtr_after); n_bad++; end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_block(5, 1'b0, 1'b0, 1'b0, o);
    n_cmp++; if (o.stall !== 5 || o.stall_bad !== 0) begin $display("FAIL bp_stall got %0d/%0d want 5/0", o.stall, o.stall_bad); n_bad++; end
    n_cmp++; if (o.rows_ok !== 4) begin $display("FAIL bp_rows got %0d want 4", o.rows_ok); n_bad++; end
    n_cmp++; if (o.done_cyc !== 41 || o.ndone !== 1) begin $display("FAIL bp_done got %0d x%0d want 41 x1", o.done_cyc, o.ndone); n_bad++; end
  endtask

  task automatic test_ignore_blk_rts();
    obs_t o;
    run_block(0, 1'b1, 1'b0, 1'b0, o);
    n_cmp++; if (o.nreq !== 16 || o.idx_bad !== 0) begin $display("FAIL ign_reqs got %0d/%0d want 16/0", o.nreq, o.idx_bad); n_bad++; end
    n_cmp++; if (o.first_row !== 33 || o.done_cyc !== 36) begin $display("FAIL ign_timing got %0d/%0d want 33/36", o.first_row, o.done_cyc); n_bad++; end
    n_cmp++; if (o.rows_ok !== 4) begin $display("FAIL ign_rows got %0d want 4", o.rows_ok); n_bad++; end
    n_cmp++; if (o.rtr_busy !== 0 || o.rtr_after !== 1) begin $display("FAIL ign_blk_rtr got %0d/%0d want 0/1", o.rtr_busy, o.rtr_after); n_bad++; end
  endtask

  task automatic test_midreset();
    obs_t o;
    bit fired;
    int busy;
    fired = 1'b0;
    @(posedge sclk); #1 blk_rts = 1'b1; row_rtr = 1'b1;
    for (int t = 1; t < 100 && !fired; t++) begin
      @(posedge sclk); #1 blk_rts = 1'b0; #1;
      if (pix_req && pix_idx == 4'd9) fired = 1'b1;
    end
    n_cmp++; if (fired !== 1'b1) begin $display("FAIL mrst_reach_idx9 got %b want 1", fired); n_bad++; end
    @(posedge sclk); #1 rsrt = 1'b1;
    @(posedge sclk); #2;
    n_cmp++; if ({pix_req, pix_idx, row_rts, row_idx, blk_done, err, blk_rtr} !== 11'd0)
      begin $display("FAIL mrst_outputs got %b want 0", {pix_req, pix_idx, row_rts, row_idx, blk_done, err, blk_rtr}); n_bad++; end
    n_cmp++; if (row_data !== 128'd0) begin $display("FAIL mrst_row_data got %h want 0", row_data); n_bad++; end
    @(posedge sclk); #1 rsrt = 1'b0;
    busy = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge sclk); #2;
      if (row_rts || pix_req) busy++;
    end
    n_cmp++; if (busy !== 0) begin $display("FAIL mrst_no_rows got %0d want 0", busy); n_bad++; end
    run_block(0, 1'b0, 1'b0, 1'b0, o);
    n_cmp++; if (o.rows_ok !== 4 || o.done_cyc !== 36) begin $display("FAIL mrst_fresh got %0d/%0d want 4/36", o.rows_ok, o.done_cyc); n_bad++; end
  endtask

  task automatic test_back_to_back();
    obs_t a, b;
    run_block(0, 1'b0, 1'b1, 1'b0, a);
    run_block(0, 1'b0, 1'b0, 1'b1, b);
    n_cmp++; if (a.rows_ok !== 4 || a.done_cyc !== 36) begin $display("FAIL b2b_first got %0d/%0d want 4/36", a.rows_ok, a.done_cyc); n_bad++; end
    n_cmp++; if (b.rtr0 !== 1) begin $display("FAIL b2b_rtr got %0d want 1", b.rtr0); n_bad++; end
    n_cmp++; if (b.first_req !== 1) begin $display("FAIL b2b_first_req got %0d want 1", b.first_req); n_bad++; end
    n_cmp++; if (b.rows_ok !== 4 || b.done_cyc !== 36) begin $display("FAIL b2b_second got %0d/%0d want 4/36", b.rows_ok, b.done_cyc); n_bad++; end
  endtask

`ifdef ETC_COLLECT_WDOG_EN
  task automatic test_wdog();
    obs_t a, b;
    hold_idx = 4;
    hold_left = 1;
    run_block(0, 1'b0, 1'b0, 1'b0, a);
    hold_idx = -1;
    n_cmp++; if (a.retry_idx !== 4) begin $display("FAIL wdog_retry_idx got %0d want 4", a.retry_idx); n_bad++; end
    n_cmp++; if (a.retry_gap !== 256) begin $display("FAIL wdog_retry_gap got %0d want 256", a.retry_gap); n_bad++; end
    n_cmp++; if (a.retry_err !== 1 || a.err_end !== 1) begin $display("FAIL wdog_err_set got %0d/%0d want 1/1", a.retry_err, a.err_end); n_bad++; end
    n_cmp++; if (a.rows_ok !== 4 || a.ndone !== 1) begin $display("FAIL wdog_rows got %0d x%0d want 4 x1", a.rows_ok, a.ndone); n_bad++; end
    run_block(0, 1'b0, 1'b0, 1'b0, b);
    n_cmp++; if (b.err_c1 !== 0) begin $display("FAIL wdog_err_clear got %0d want 0", b.err_c1); n_bad++; end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_blk_rts();
    test_midreset();
    test_back_to_back();
`ifdef ETC_COLLECT_WDOG_EN
    test_wdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
